lut_cell: RTL and testbench

Next-generation configurable logic element for the tiny-FPGA fabric. It holds NUM_OUTPUTS independent WIDTH-input LUTs that share one input vector. Truth tables load from a serial 1-bit-per-beat AXI-Stream-style config port into a shadow register, and commit atomically only when the load succeeds. Unlike the single-output LUT, it detects and recovers from malformed streams (early or missing tlast) and keeps the last good configuration in use.

---
 rtl/lut_cell_if.sv | 35 +++
 rtl/lut_cell.sv | 238 +++++++++++++++++++++++
 tb/tb_lut_cell.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_cell_if.sv
// ============================================================================
// Module      : lut_cell_if
// Description : Serial configuration stream bundle for lut_cell. One truth-
//               table bit per beat, AXI-Stream style valid/ready handshake
//               with a last-beat marker.
//   cfg_tvalid  source -> sink   beat valid
//   cfg_tready  sink   -> source beat accepted when tvalid && tready
//   cfg_tdata   source -> sink   configuration bit
//   cfg_tlast   source -> sink   final beat of the bitstream
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lut_cell_if;
  logic cfg_tvalid;
  logic cfg_tready;
  logic cfg_tdata;
  logic cfg_tlast;

  modport master (
    output cfg_tvalid,
    output cfg_tdata,
    output cfg_tlast,
    input  cfg_tready
  );

  modport slave (
    input  cfg_tvalid,
    input  cfg_tdata,
    input  cfg_tlast,
    output cfg_tready
  );
endinterface

`default_nettype wire

// File: rtl/lut_cell.sv
// ============================================================================
// Module      : lut_cell
// Description : Configurable logic element with NUM_OUTPUTS independent
//               WIDTH-input LUTs sharing one select vector. Truth tables are
//               streamed in one bit per beat into a shadow register and copied
//               to the active tables only when a complete, well-formed
//               bitstream arrives. Malformed streams (early tlast, missing
//               tlast) raise a one-cycle cfg_error and leave the previous
//               configuration in use.
// Ports       :
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg        reconfiguration request (level)
//   cfg_bus    serial config stream (lut_cell_if.slave)
//   cfg_ready  a valid configuration is committed
//   cfg_error  one-cycle pulse on a malformed bitstream
//   run        enable evaluation
//   run_in     LUT select vector
//   run_out    LUT results, bit k is LUT k
// Options     : LUT_CELL_FF_EN - appends NUM_OUTPUTS mode bits to the
//               bitstream; mode bit k selects a registered output for LUT k.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_cell #(
  parameter int WIDTH       = 4,
  parameter int NUM_OUTPUTS = 2
) (
  input  wire                    clk,
  input  wire                    rst,
  input  wire                    cfg,
  lut_cell_if.slave              cfg_bus,
  output logic                   cfg_ready,
  output logic                   cfg_error,
  input  wire                    run,
  input  wire  [WIDTH-1:0]       run_in,
  output logic [NUM_OUTPUTS-1:0] run_out
);

  localparam int DEPTH      = 1 << WIDTH;
  localparam int TABLE_BITS = NUM_OUTPUTS * DEPTH;
`ifdef LUT_CELL_FF_EN
  localparam int CFG_BITS   = TABLE_BITS + NUM_OUTPUTS;
`else
  localparam int CFG_BITS   = TABLE_BITS;
`endif
  localparam int CNT_W      = $clog2(CFG_BITS + 1);
  localparam int IDX_W      = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CFG_BITS - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_IDLE  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       beat_cnt;
  logic [IDX_W-1:0]       beat_idx;
  logic [CFG_BITS-1:0]    shadow;
  logic [CFG_BITS-1:0]    shadow_upd;
  logic [CFG_BITS-1:0]    active;
  logic [NUM_OUTPUTS-1:0] lut_val;
  logic                   tready;
  logic                   store;
  logic                   cnt_clear;
  logic                   commit;
  logic                   discard;
  logic                   malformed;

  assign cfg_bus.cfg_tready = tready;

  // The counter is one bit wider than an index only when CFG_BITS is a power
  // of two; while loading it never exceeds CFG_BITS-1, so the low bits suffice.
  assign beat_idx = beat_cnt[IDX_W-1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tready    = 1'b0;
    store     = 1'b0;
    cnt_clear = 1'b0;
    commit    = 1'b0;
    discard   = 1'b0;
    malformed = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (cfg) begin
          state_nxt = ST_LOAD;
          cnt_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        tready = 1'b1;
        if (cfg_bus.cfg_tvalid) begin
          store = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            if (cfg_bus.cfg_tlast) begin
              commit    = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              // Stream is longer than expected: swallow the rest until tlast.
              malformed = 1'b1;
              state_nxt = ST_DRAIN;
            end
          end else if (cfg_bus.cfg_tlast) begin
            malformed = 1'b1;
            discard   = 1'b1;
            state_nxt = cfg_ready ? ST_IDLE : ST_INIT;
          end
        end
      end
      ST_DRAIN: begin
        tready = 1'b1;
        if (cfg_bus.cfg_tvalid && cfg_bus.cfg_tlast) begin
          state_nxt = cfg_ready ? ST_IDLE : ST_INIT;
        end
      end
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_RUN;
        end else if (cfg) begin
          state_nxt = ST_LOAD;
          cnt_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          if (cfg) begin
            state_nxt = ST_LOAD;
            cnt_clear = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Shadow image including the beat currently on the bus, so the final beat
  // lands in the active tables on the same edge as its handshake.
  always_comb begin
    shadow_upd           = shadow;
    shadow_upd[beat_idx] = cfg_bus.cfg_tdata;
  end

  // --------------------------------------------------------------------------
  // Configuration datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      shadow    <= '0;
      active    <= '0;
      cfg_ready <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= malformed;
      if (cnt_clear) begin
        beat_cnt <= '0;
      end else if (store) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (discard) begin
        shadow <= '0;
      end else if (store) begin
        shadow <= shadow_upd;
      end
      if (commit) begin
        active    <= shadow_upd;
        cfg_ready <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // LUT lookup
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lut
    logic [DEPTH-1:0] tbl;
    assign tbl        = active[k*DEPTH +: DEPTH];
    assign lut_val[k] = tbl[run_in];
  end

`ifdef LUT_CELL_FF_EN
  logic [NUM_OUTPUTS-1:0] mode;
  logic [NUM_OUTPUTS-1:0] ff_q;

  assign mode = active[TABLE_BITS +: NUM_OUTPUTS];

  // Registered outputs track the lookup only while running and hold
  // otherwise; a fresh commit restarts them from zero.
  always_ff @(posedge clk) begin
    if (rst || commit) begin
      ff_q <= '0;
    end else if (state == ST_RUN) begin
      ff_q <= lut_val;
    end
  end

  always_comb begin
    run_out = ff_q & mode;
    if (state == ST_RUN) begin
      run_out = run_out | (lut_val & ~mode);
    end
  end
`else
  always_comb begin
    run_out = '0;
    if (state == ST_RUN) begin
      run_out = lut_val;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_cell.sv
// ============================================================================
// Module      : tb_lut_cell
// Description : Self-checking bench for lut_cell (WIDTH=2, NUM_OUTPUTS=2).
//               Expected outputs come from integer truth tables held in the
//               bench: output k for select s is bit s of table k. Honours
//               LUT_CELL_FF_EN by appending mode bits to every stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_cell;

  localparam int W     = 2;
  localparam int NO    = 2;
  localparam int DEPTH = 4;
`ifdef LUT_CELL_FF_EN
  localparam int CFG_BITS = NO * DEPTH + NO;
`else
  localparam int CFG_BITS = NO * DEPTH;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg = 1'b0;
  logic          run = 1'b0;
  logic [W-1:0]  run_in = '0;
  logic          cfg_ready;
  logic          cfg_error;
  logic [NO-1:0] run_out;

  int total = 0;
  int bad   = 0;
  int m_lut [NO];

  lut_cell_if cif ();

  lut_cell #(.WIDTH(W), .NUM_OUTPUTS(NO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg),
    .cfg_bus   (cif),
    .cfg_ready (cfg_ready),
    .cfg_error (cfg_error),
    .run       (run),
    .run_in    (run_in),
    .run_out   (run_out)
  );

  always #5 clk = ~clk;

  function automatic logic lut_bit(input int tbl, input int idx);
    return ((tbl >> idx) & 1) != 0;
  endfunction

  function automatic logic [NO-1:0] expect_out(input int idx);
    logic [NO-1:0] e;
    for (int k = 0; k < NO; k++) e[k] = lut_bit(m_lut[k], idx);
    return e;
  endfunction

  // Bitstream image: beat i carries bit i.
  function automatic logic [15:0] pack(input int l0, input int l1, input int mode);
    int v;
    v = (l0 & 15) | ((l1 & 15) << 4);
`ifdef LUT_CELL_FF_EN
    v = v | ((mode & 3) << 8);
`endif
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cfg = 1'b0; run = 1'b0; run_in = '0;
    cif.cfg_tvalid = 1'b0; cif.cfg_tdata = 1'b0; cif.cfg_tlast = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < NO; k++) m_lut[k] = 0;
  endtask

  task automatic begin_load();
    cfg = 1'b1;
    tick();
    cfg = 1'b0;
  endtask

  // Presents nbeats beats; tlast rides on beat number last_at (1-based, 0 = never).
  // With gaps, tvalid drops every other cycle and run toggles meanwhile.
  task automatic stream(input logic [15:0] bits, input int nbeats, input int last_at,
                        input bit gaps, output int errs, output int ready_low);
    int sent;
    int cyc;
    sent = 0; cyc = 0; errs = 0; ready_low = 0;
    while (sent < nbeats && cyc < 100) begin
      cyc++;
      if (gaps && (cyc % 2 == 0)) begin
        cif.cfg_tvalid = 1'b0;
        run = ~run;
      end else begin
        cif.cfg_tvalid = 1'b1;
        cif.cfg_tdata  = bits[sent];
        cif.cfg_tlast  = (sent + 1 == last_at);
      end
      #1;
      if (cif.cfg_tvalid && cif.cfg_tready) sent++;
      tick();
      if (cfg_error) errs++;
      if (!cfg_ready) ready_low++;
    end
    cif.cfg_tvalid = 1'b0; cif.cfg_tlast = 1'b0; run = 1'b0;
    total++;
    if (sent !== nbeats) begin
      bad++;
      $display("FAIL stream_timeout: beats accepted %0d, required %0d", sent, nbeats);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cif.cfg_tvalid = 1'b1; run = 1'b1; run_in = 2'd3;
    #1;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
    total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", cfg_error); end
    total++; if (cif.cfg_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", cif.cfg_tready); end
    total++; if (run_out !== 2'b00) begin bad++; $display("FAIL reset_run_out: got %b want 00", run_out); end
    tick();
    total++; if (cif.cfg_tready !== 1'b0 || run_out !== 2'b00) begin
      bad++; $display("FAIL init_idle: tready=%b run_out=%b want 0/00", cif.cfg_tready, run_out);
    end
    cif.cfg_tvalid = 1'b0; run = 1'b0;
  endtask

  task automatic test_basic_load();
    int e, rl;
    begin_load();
    total++; if (cif.cfg_tready !== 1'b1) begin bad++; $display("FAIL load_tready: got %b want 1", cif.cfg_tready); end
    stream(pack(4'b1000, 4'b0110, 0), CFG_BITS, CFG_BITS, 1'b0, e, rl);
    m_lut[0] = 4'b1000; m_lut[1] = 4'b0110;
    total++; if (e !== 0) begin bad++; $display("FAIL basic_err: pulses %0d want 0", e); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", cfg_ready); end
    total++; if (cif.cfg_tready !== 1'b0) begin bad++; $display("FAIL idle_tready: got %b want 0", cif.cfg_tready); end
    run = 1'b1;
    tick();
    for (int s = 0; s < DEPTH; s++) begin
      run_in = W'(3 - s);
      #1;
      total++; if (run_out !== expect_out(3 - s)) begin
        bad++; $display("FAIL basic_eval sel=%0d: got %b want %b", 3 - s, run_out, expect_out(3 - s));
      end
    end
    run = 1'b0; run_in = 2'd3;
    tick();
    total++; if (run_out !== 2'b00) begin bad++; $display("FAIL idle_out: got %b want 00", run_out); end
  endtask

  task automatic test_random_tables();
    int e, rl, l0, l1, s;
    bit g;
    for (int it = 0; it < 4; it++) begin
      l0 = int'($urandom_range(0, 15)); l1 = int'($urandom_range(0, 15));
      g  = 1'($urandom_range(0, 1));
      begin_load();
      stream(pack(l0, l1, 0), CFG_BITS, CFG_BITS, g, e, rl);
      m_lut[0] = l0; m_lut[1] = l1;
      total++; if (e !== 0 || cfg_ready !== 1'b1) begin
        bad++; $display("FAIL rand_load it=%0d: err=%0d ready=%b want 0/1", it, e, cfg_ready);
      end
      run = 1'b1;
      tick();
      for (int j = 0; j < 6; j++) begin
        s = int'($urandom_range(0, 3));
        run_in = W'(s);
        #1;
        total++; if (run_out !== expect_out(s)) begin
          bad++; $display("FAIL rand_eval t=%0h/%0h sel=%0d: got %b want %b", l0, l1, s, run_out, expect_out(s));
        end
        tick();
      end
      run = 1'b0;
      tick();
    end
  endtask

  task automatic test_gaps();
    int e, rl;
    begin_load();
    stream(pack(4'b1000, 4'b0110, 0), CFG_BITS, CFG_BITS, 1'b1, e, rl);
    m_lut[0] = 4'b1000; m_lut[1] = 4'b0110;
    total++; if (e !== 0 || cfg_ready !== 1'b1 || cif.cfg_tready !== 1'b0) begin
      bad++; $display("FAIL gaps_commit: err=%0d ready=%b tready=%b want 0/1/0", e, cfg_ready, cif.cfg_tready);
    end
    run = 1'b1;
    tick();
    for (int s = 0; s < DEPTH; s++) begin
      run_in = W'(s);
      #1;
      total++; if (run_out !== expect_out(s)) begin
        bad++; $display("FAIL gaps_eval sel=%0d: got %b want %b", s, run_out, expect_out(s));
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    int e, rl;
    run = 1'b1; cfg = 1'b1; run_in = 2'd1;
    tick();
    total++; if (cif.cfg_tready !== 1'b0 || run_out !== expect_out(1)) begin
      bad++; $display("FAIL run_priority: tready=%b out=%b want 0/%b", cif.cfg_tready, run_out, expect_out(1));
    end
    run = 1'b0;
    tick();
    cfg = 1'b0;
    total++; if (cif.cfg_tready !== 1'b1 || run_out !== 2'b00) begin
      bad++; $display("FAIL run_to_load: tready=%b out=%b want 1/00", cif.cfg_tready, run_out);
    end
    stream(pack(4'b1000, 4'b0110, 0), CFG_BITS, CFG_BITS, 1'b0, e, rl);
    total++; if (e !== 0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL prio_reload: err=%0d ready=%b want 0/1", e, cfg_ready);
    end
  endtask

  task automatic test_drain();
    int e, rl;
    logic [15:0] junk;
    junk = 16'($urandom);
    begin_load();
    stream(junk, CFG_BITS + 4, CFG_BITS + 4, 1'b0, e, rl);
    total++; if (e !== 1) begin bad++; $display("FAIL drain_err: pulses %0d want 1", e); end
    total++; if (rl !== 0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL drain_ready: low cycles %0d ready=%b want 0/1", rl, cfg_ready);
    end
    cif.cfg_tvalid = 1'b1;
    #1;
    total++; if (cif.cfg_tready !== 1'b0) begin bad++; $display("FAIL drain_exit: tready=%b want 0", cif.cfg_tready); end
    cif.cfg_tvalid = 1'b0;
    run = 1'b1; run_in = 2'd3;
    tick();
    total++; if (run_out !== expect_out(3)) begin
      bad++; $display("FAIL drain_keep: got %b want %b", run_out, expect_out(3));
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_early_tlast();
    int e, rl;
    // Early tlast with a committed table keeps the old table usable.
    begin_load();
    stream(16'hFFFF, 3, 3, 1'b0, e, rl);
    total++; if (e !== 1 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL early_keep: err=%0d ready=%b want 1/1", e, cfg_ready);
    end
    run = 1'b1; run_in = 2'd3;
    tick();
    total++; if (run_out !== expect_out(3)) begin
      bad++; $display("FAIL early_old_table: got %b want %b", run_out, expect_out(3));
    end
    run = 1'b0;
    tick();
    // From a fresh reset it falls back to INIT.
    do_reset();
    begin_load();
    stream(pack(4'b1000, 4'b0110, 0), 5, 5, 1'b0, e, rl);
    total++; if (e !== 1 || cfg_error !== 1'b1) begin
      bad++; $display("FAIL early_err: pulses %0d now=%b want 1/1", e, cfg_error);
    end
    run = 1'b1; run_in = 2'd3;
    tick();
    total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL early_pulse_len: got %b want 0", cfg_error); end
    total++; if (cfg_ready !== 1'b0 || cif.cfg_tready !== 1'b0 || run_out !== 2'b00) begin
      bad++; $display("FAIL early_init: ready=%b tready=%b out=%b want 0/0/00", cfg_ready, cif.cfg_tready, run_out);
    end
    run = 1'b0;
    begin_load();
    stream(pack(4'b1000, 4'b0110, 0), CFG_BITS, CFG_BITS, 1'b0, e, rl);
    m_lut[0] = 4'b1000; m_lut[1] = 4'b0110;
    total++; if (e !== 0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL early_recover: err=%0d ready=%b want 0/1", e, cfg_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int e, rl, l0, l1;
    begin_load();
    stream(16'h00FF, 3, 0, 1'b0, e, rl);
    cif.cfg_tvalid = 1'b1; cif.cfg_tdata = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; cif.cfg_tvalid = 1'b0;
    for (int k = 0; k < NO; k++) m_lut[k] = 0;
    run = 1'b1; run_in = 2'd3;
    #1;
    total++; if (cfg_ready !== 1'b0 || cif.cfg_tready !== 1'b0 || run_out !== 2'b00) begin
      bad++; $display("FAIL midrst_state: ready=%b tready=%b out=%b want 0/0/00", cfg_ready, cif.cfg_tready, run_out);
    end
    run = 1'b0;
    l0 = int'($urandom_range(0, 15)); l1 = int'($urandom_range(0, 15));
    begin_load();
    stream(pack(l0, l1, 0), CFG_BITS, CFG_BITS, 1'b0, e, rl);
    m_lut[0] = l0; m_lut[1] = l1;
    run = 1'b1;
    tick();
    for (int s = 0; s < DEPTH; s++) begin
      run_in = W'(s);
      #1;
      total++; if (run_out !== expect_out(s)) begin
        bad++; $display("FAIL midrst_reload sel=%0d: got %b want %b", s, run_out, expect_out(s));
      end
    end
    run = 1'b0;
    tick();
  endtask

`ifdef LUT_CELL_FF_EN
  task automatic test_ff_mode();
    int e, rl;
    do_reset();
    begin_load();
    stream(pack(4'b1000, 4'b0110, 1), CFG_BITS, CFG_BITS, 1'b0, e, rl);
    m_lut[0] = 4'b1000; m_lut[1] = 4'b0110;
    run_in = 2'd3; run = 1'b1;
    tick();  // enters RUN; LUT0 flop still cleared
    total++; if (run_out !== {lut_bit(m_lut[1], 3), 1'b0}) begin
      bad++; $display("FAIL ff_enter: got %b want %b", run_out, {lut_bit(m_lut[1], 3), 1'b0});
    end
    tick();
    total++; if (run_out !== {lut_bit(m_lut[1], 3), lut_bit(m_lut[0], 3)}) begin
      bad++; $display("FAIL ff_rise: got %b want 01", run_out);
    end
    run_in = 2'd1;
    #1;
    total++; if (run_out !== {lut_bit(m_lut[1], 1), lut_bit(m_lut[0], 3)}) begin
      bad++; $display("FAIL ff_comb_same_cycle: got %b want 11", run_out);
    end
    tick();
    total++; if (run_out !== {lut_bit(m_lut[1], 1), lut_bit(m_lut[0], 1)}) begin
      bad++; $display("FAIL ff_follow: got %b want 10", run_out);
    end
    run_in = 2'd3; run = 1'b0;
    tick(); tick();
    total++; if (run_out !== {1'b0, lut_bit(m_lut[0], 3)}) begin
      bad++; $display("FAIL ff_hold: got %b want 01", run_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (run_out !== 2'b00) begin bad++; $display("FAIL ff_reset: got %b want 00", run_out); end
  endtask
`endif

  initial begin
    cif.cfg_tvalid = 1'b0; cif.cfg_tdata = 1'b0; cif.cfg_tlast = 1'b0;
    test_reset();
    test_basic_load();
    test_random_tables();
    test_gaps();
    test_priority();
    test_drain();
    test_early_tlast();
    test_reset_mid_load();
`ifdef LUT_CELL_FF_EN
    test_ff_mode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
